// File: rtl/bin_counter.sv
// Free-running WIDTH-bit binary up/down counter with synchronous active-high reset.
// i_mode selects the direction each edge; o_cnt comes straight from the count register.
module bin_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_mode,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_next;

   // WIDTH-bit arithmetic: carry and borrow fall off, giving modulo wrap both ways.
   always_comb begin
      w_cnt_next = r_cnt;
      if (i_mode) begin
         w_cnt_next = r_cnt - WIDTH'(1);
      end else begin
         w_cnt_next = r_cnt + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: tb/tb_bin_counter.sv
// Self-checking bench for bin_counter: a reference model pushes the expected count per edge
// into a queue, and each test pops and compares it after the edge.
module tb_bin_counter;

   localparam int unsigned Width = 4;
   localparam int          Modulus = 16;

   logic             i_clk;
   logic             i_rst;
   logic             i_mode;
   logic [Width-1:0] o_cnt;

   int               checks;
   int               errors;
   int               m_cnt;
   logic [Width-1:0] exp_q[$];
   logic [Width-1:0] exp_v;

   bin_counter #(
      .WIDTH(Width)
   ) u_dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_mode(i_mode),
      .o_cnt (o_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Drives one edge, records the model's expected result, and returns 1 ns after the edge.
   task automatic drive_edge(input logic rst, input logic mode);
      i_rst  = rst;
      i_mode = mode;
      if (rst) begin
         m_cnt = 0;
      end else if (mode) begin
         m_cnt = (m_cnt + Modulus - 1) % Modulus;
      end else begin
         m_cnt = (m_cnt + 1) % Modulus;
      end
      exp_q.push_back(Width'(m_cnt));
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      drive_edge(1'b1, 1'b0);
      exp_v = exp_q.pop_front();
      checks++;
      if (o_cnt !== exp_v || o_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset: o_cnt=%0d expected %0d", o_cnt, exp_v);
      end
   endtask

   task automatic test_up_wrap();
      for (int i = 1; i <= 25; i++) begin
         drive_edge(1'b0, 1'b0);
         exp_v = exp_q.pop_front();
         checks++;
         if (o_cnt !== exp_v) begin
            errors++;
            $display("FAIL up_count step %0d: o_cnt=%0d expected %0d", i, o_cnt, exp_v);
         end
         if (i == 16) begin
            checks++;
            if (o_cnt !== 4'd0) begin
               errors++;
               $display("FAIL up_wrap: o_cnt=%0d expected 0", o_cnt);
            end
         end
      end
      checks++;
      if (o_cnt !== 4'd9) begin
         errors++;
         $display("FAIL up_end: o_cnt=%0d expected 9", o_cnt);
      end
   endtask

   task automatic test_direction_switch();
      drive_edge(1'b0, 1'b1);
      exp_v = exp_q.pop_front();
      checks++;
      if (o_cnt !== exp_v || o_cnt !== 4'd8) begin
         errors++;
         $display("FAIL dir_switch: o_cnt=%0d expected %0d", o_cnt, exp_v);
      end
   endtask

   task automatic test_down_wrap();
      for (int i = 2; i <= 25; i++) begin
         drive_edge(1'b0, 1'b1);
         exp_v = exp_q.pop_front();
         checks++;
         if (o_cnt !== exp_v) begin
            errors++;
            $display("FAIL down_count step %0d: o_cnt=%0d expected %0d", i, o_cnt, exp_v);
         end
         if (i == 10) begin
            checks++;
            if (o_cnt !== 4'd15) begin
               errors++;
               $display("FAIL down_wrap: o_cnt=%0d expected 15", o_cnt);
            end
         end
      end
      checks++;
      if (o_cnt !== 4'd0) begin
         errors++;
         $display("FAIL down_end: o_cnt=%0d expected 0", o_cnt);
      end
   endtask

   task automatic test_reset_priority();
      for (int i = 0; i < 11; i++) begin
         drive_edge(1'b0, 1'b1);
         exp_v = exp_q.pop_front();
         checks++;
         if (o_cnt !== exp_v) begin
            errors++;
            $display("FAIL prio_setup step %0d: o_cnt=%0d expected %0d", i, o_cnt, exp_v);
         end
      end
      drive_edge(1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      checks++;
      if (o_cnt !== exp_v || o_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_priority: o_cnt=%0d expected %0d", o_cnt, exp_v);
      end
      drive_edge(1'b0, 1'b1);
      exp_v = exp_q.pop_front();
      checks++;
      if (o_cnt !== exp_v || o_cnt !== 4'd15) begin
         errors++;
         $display("FAIL resume_down: o_cnt=%0d expected %0d", o_cnt, exp_v);
      end
   endtask

   task automatic test_mode_toggle();
      logic [Width-1:0] want[4];
      want[0] = 4'd4;
      want[1] = 4'd3;
      want[2] = 4'd4;
      want[3] = 4'd3;
      for (int i = 0; i < 12; i++) begin
         drive_edge(1'b0, 1'b1);
         void'(exp_q.pop_front());
      end
      checks++;
      if (o_cnt !== 4'd3) begin
         errors++;
         $display("FAIL toggle_setup: o_cnt=%0d expected 3", o_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         drive_edge(1'b0, (i % 2) == 1);
         exp_v = exp_q.pop_front();
         checks++;
         if (o_cnt !== exp_v || o_cnt !== want[i]) begin
            errors++;
            $display("FAIL toggle step %0d: o_cnt=%0d expected %0d", i, o_cnt, want[i]);
         end
      end
   endtask

   task automatic test_back_to_back_reset();
      for (int i = 0; i < 3; i++) begin
         drive_edge(1'b1, i[0]);
         exp_v = exp_q.pop_front();
         checks++;
         if (o_cnt !== exp_v) begin
            errors++;
            $display("FAIL b2b_reset %0d: o_cnt=%0d expected %0d", i, o_cnt, exp_v);
         end
      end
      drive_edge(1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      checks++;
      if (o_cnt !== exp_v || o_cnt !== 4'd1) begin
         errors++;
         $display("FAIL b2b_resume_up: o_cnt=%0d expected %0d", o_cnt, exp_v);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_cnt  = 0;
      i_rst  = 1'b1;
      i_mode = 1'b0;
      test_reset();
      test_up_wrap();
      test_direction_switch();
      test_down_wrap();
      test_reset_priority();
      test_mode_toggle();
      test_back_to_back_reset();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
